// File: rtl/cp0_exc_sequencer.sv
// Sequences CP0 writes for exception entry, ERET and MTC0 through a single write port,
// stalling the core during multi-cycle sequences and redirecting the PC at the end.
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00400004,
  parameter int          STATUS_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        teq_i,
  input  logic        teq_eq_i,
  input  logic        eret_i,
  input  logic        mtc0_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] npc_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic        stall_o,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        pc_redirect_o,
  output logic [31:0] redirect_addr_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_EPC     = 3'd1,
    W_CAUSE   = 3'd2,
    W_STATUS  = 3'd3,
    ER_STATUS = 3'd4,
    REDIRECT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] addr_q, addr_d;   // saved npc (exception) or EPC (ERET)
  logic        eret_q, eret_d;

  logic        exc_take;
  logic [4:0]  exc_code;

  logic        stall, we, redirect;
  logic [4:0]  waddr;
  logic [31:0] wdata, raddr;

  always_comb begin
    exc_take = 1'b0;
    exc_code = 5'd0;
    if (status_i[0]) begin
      if (syscall_i && status_i[1]) begin
        exc_take = 1'b1;
        exc_code = 5'b01000;
      end else if (break_i && status_i[2]) begin
        exc_take = 1'b1;
        exc_code = 5'b01001;
      end else if (teq_i && teq_eq_i && status_i[3]) begin
        exc_take = 1'b1;
        exc_code = 5'b01101;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    addr_d   = addr_q;
    eret_d   = eret_q;
    stall    = 1'b0;
    we       = 1'b0;
    waddr    = 5'd0;
    wdata    = 32'd0;
    redirect = 1'b0;
    raddr    = 32'd0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (eret_i) begin
            stall   = 1'b1;
            addr_d  = epc_i;
            eret_d  = 1'b1;
            state_d = ER_STATUS;
          end else if (exc_take) begin
            stall   = 1'b1;
            addr_d  = npc_i;
            code_d  = exc_code;
            eret_d  = 1'b0;
            state_d = W_EPC;
          end else if (mtc0_i) begin
            we    = 1'b1;
            waddr = rd_i;
            wdata = rt_data_i;
          end
        end
      end
      W_EPC: begin
        stall   = 1'b1;
        we      = 1'b1;
        waddr   = 5'd14;
        wdata   = addr_q;
        state_d = W_CAUSE;
      end
      W_CAUSE: begin
        stall   = 1'b1;
        we      = 1'b1;
        waddr   = 5'd13;
        wdata   = (cause_i & ~32'h0000007C) | {25'd0, code_q, 2'b00};
        state_d = W_STATUS;
      end
      W_STATUS: begin
        stall   = 1'b1;
        we      = 1'b1;
        waddr   = 5'd12;
        wdata   = status_i << STATUS_SHIFT;
        state_d = REDIRECT;
      end
      ER_STATUS: begin
        stall   = 1'b1;
        we      = 1'b1;
        waddr   = 5'd12;
        wdata   = status_i >> STATUS_SHIFT;
        state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect = 1'b1;
        raddr    = eret_q ? addr_q : EXC_VECTOR;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 5'd0;
      addr_q  <= 32'd0;
      eret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      eret_q  <= eret_d;
    end
  end

  // Outputs are forced quiet while reset is held, even though IDLE decode is combinational.
  always_comb begin
    stall_o         = stall & ~rst;
    cp0_we_o        = we & ~rst;
    cp0_waddr_o     = rst ? 5'd0 : waddr;
    cp0_wdata_o     = rst ? 32'd0 : wdata;
    pc_redirect_o   = redirect & ~rst;
    redirect_addr_o = rst ? 32'd0 : raddr;
    busy_o          = (state_q != IDLE) & ~rst;
  end

endmodule

// File: doc/cp0_exc_sequencer.md
Name: cp0_exc_sequencer

Overview:
- Multi-cycle controller that sequences every CP0 register update for the CPU core. It issues exception entry (SYSCALL/BREAK/TEQ), ERET return and MTC0 writes through one CP0 write port.
- Sits between the decoder/PC logic and the CP0 register file. It stalls the core while a sequence runs, then redirects the PC to the exception vector or to EPC.

Parameters:
- EXC_VECTOR, 32'h00400004, exception handler entry address.
- STATUS_SHIFT, 5, Status shift amount on exception entry (left) and ERET (right).

Ports:
- clk, input, 1, core clock; all state changes on posedge.
- rst, input, 1, synchronous reset, active-high.
- valid_i, input, 1, decoded instruction present this cycle.
- syscall_i, input, 1, instruction is SYSCALL.
- break_i, input, 1, instruction is BREAK.
- teq_i, input, 1, instruction is TEQ.
- teq_eq_i, input, 1, TEQ operands equal.
- eret_i, input, 1, instruction is ERET.
- mtc0_i, input, 1, instruction is MTC0.
- rd_i, input, 5, MTC0 target CP0 register.
- rt_data_i, input, 32, MTC0 write data.
- npc_i, input, 32, next PC of the current instruction; this value is saved to EPC.
- status_i, input, 32, current CP0 Status (reg 12).
- cause_i, input, 32, current CP0 Cause (reg 13).
- epc_i, input, 32, current CP0 EPC (reg 14).
- stall_o, output, 1, freeze PC and decode.
- cp0_we_o, output, 1, CP0 write enable.
- cp0_waddr_o, output, 5, CP0 write address.
- cp0_wdata_o, output, 32, CP0 write data.
- pc_redirect_o, output, 1, PC loads redirect_addr_o this cycle.
- redirect_addr_o, output, 32, redirect target.
- busy_o, output, 1, state != IDLE.

Behaviour:
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, ER_STATUS, REDIRECT. Encoding is free.
- Reset: state=IDLE, all latched fields=0. Every output is 0 during reset and in the first IDLE cycle with no request. Reset during any state aborts the sequence and issues no further CP0 writes or redirect.
- Exception take condition, evaluated in IDLE with valid_i=1:
  - status_i[0]=1 (global enable), and
  - one of: syscall_i with status_i[1]=1 (code 5'b01000); break_i with status_i[2]=1 (code 5'b01001); teq_i with teq_eq_i=1 and status_i[3]=1 (code 5'b01101).
  - Priority: SYSCALL > BREAK > TEQ.
  - A masked exception or a TEQ with teq_eq_i=0 is a no-op: no stall, no write.
- Priority among classes in IDLE: ERET > taken exception > MTC0.
  - Example: eret_i=1 together with syscall_i=1 is treated as ERET only.
- Exception sequence:
  - Accept cycle (IDLE): latch code and npc_i; stall_o=1; no write this cycle.
  - W_EPC: we=1, addr=14, data=latched npc; stall_o=1.
  - W_CAUSE: we=1, addr=13, data={cause_i[31:7], code, cause_i[1:0]}; stall_o=1.
  - W_STATUS: we=1, addr=12, data=status_i<<STATUS_SHIFT (logical shift, zero fill, 32-bit truncation); stall_o=1.
  - REDIRECT: pc_redirect_o=1, redirect_addr_o=EXC_VECTOR, stall_o=0, we=0; next state IDLE.
  - Accept to redirect = 4 cycles.
- ERET sequence:
  - Accept cycle (IDLE): latch epc_i; stall_o=1.
  - ER_STATUS: we=1, addr=12, data=status_i>>STATUS_SHIFT (logical); stall_o=1.
  - REDIRECT: pc_redirect_o=1, redirect_addr_o=latched EPC; next state IDLE.
  - ERET is never masked.
- MTC0: handled combinationally in IDLE with valid_i=1 and no higher-priority request.
  - Outputs: we=1, addr=rd_i, data=rt_data_i. No stall, no state change.
  - Back-to-back MTC0 is allowed every cycle.
- In every non-IDLE state, all request inputs are ignored; upstream holds them under stall_o.
- The instruction held at REDIRECT is discarded by the PC redirect.
- The first accept is possible in the cycle after REDIRECT.
- Outputs cp0_we_o, cp0_waddr_o, cp0_wdata_o and redirect_addr_o are 0 whenever they are not asserted.

Test Plan:
- Reset, then SYSCALL with status_i=32'hF, npc_i=32'h00400020, cause_i=0:
  - writes EPC=32'h00400020, Cause=32'h00000020, Status=32'h1E0;
  - REDIRECT to 32'h00400004 on cycle 4;
  - stall_o=1 for cycles 0–3.
- BREAK with status_i=32'h0B (bit2=0) -> no stall, no write, busy_o stays 0.
- TEQ with teq_eq_i=0, then with teq_eq_i=1, status_i=32'hF:
  - the first is ignored;
  - the second writes Cause code 5'b01101 (Cause=32'h34).
- ERET with status_i=32'h1E0, epc_i=32'h00400020:
  - writes Status=32'hF;
  - redirects to 32'h00400020 two cycles after accept.
- MTC0 rd=12, data=32'h7 on three consecutive cycles -> three single-cycle writes, stall_o=0 throughout.
- Assert rst during W_CAUSE -> the next cycle shows IDLE, no Status write, no redirect; a following SYSCALL sequences normally.
